// File: rtl/dcache_indirect_ctrl.sv
// LDI/STI sequencer in front of the D-cache: pointer read, one idle gap, then the data access.
// Plain accesses pass straight through. Define DCACHE_INDIRECT_ALIGN_EN to clear pointer bit0 on word accesses.
module dcache_indirect_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        indirect,
  input  logic [15:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [1:0]  cpu_byte_enable,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_resp,
  output logic [15:0] cpu_rdata,
  output logic [15:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PTR  = 3'd1;
  localparam logic [2:0] GAP  = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic        req_s, rd_s, wr_s;
  logic [15:0] ptr_cap_s;
  logic        cpu_resp_s, mem_read_s, mem_write_s;
  logic [15:0] cpu_rdata_s, mem_address_s, mem_wdata_s;
  logic [1:0]  mem_be_s;

  // A simultaneous read and write is always served as a read.
  assign req_s = cpu_read | cpu_write;
  assign rd_s  = cpu_read;
  assign wr_s  = cpu_write & ~cpu_read;

`ifdef DCACHE_INDIRECT_ALIGN_EN
  assign ptr_cap_s = (cpu_byte_enable == 2'b11) ? {mem_rdata[15:1], 1'b0} : mem_rdata;
`else
  assign ptr_cap_s = mem_rdata;
`endif

  // Next-state and memory/cpu drive for each phase of the access.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cpu_resp_s    = 1'b0;
    cpu_rdata_s   = 16'h0000;
    mem_address_s = 16'h0000;
    mem_read_s    = 1'b0;
    mem_write_s   = 1'b0;
    mem_be_s      = 2'b00;
    mem_wdata_s   = 16'h0000;
    case (state_q)
      IDLE: begin
        if (!indirect) begin
          mem_address_s = cpu_address;
          mem_read_s    = rd_s;
          mem_write_s   = wr_s;
          mem_be_s      = cpu_byte_enable;
          mem_wdata_s   = cpu_wdata;
          cpu_resp_s    = mem_resp;
          cpu_rdata_s   = mem_rdata;
        end else if (req_s) begin
          state_d = PTR;
        end else begin
          state_d = IDLE;
        end
      end
      PTR: begin
        mem_address_s = cpu_address;
        mem_read_s    = 1'b1;
        mem_be_s      = 2'b11;
        if (mem_resp) begin
          ptr_d   = ptr_cap_s;
          state_d = GAP;
        end else if (!req_s) begin
          state_d = IDLE;
        end else begin
          state_d = PTR;
        end
      end
      GAP: begin
        state_d = DATA;
      end
      DATA: begin
        mem_address_s = ptr_q;
        mem_read_s    = rd_s;
        mem_write_s   = wr_s;
        mem_be_s      = cpu_byte_enable;
        mem_wdata_s   = cpu_wdata;
        if (mem_resp) begin
          cpu_resp_s  = 1'b1;
          cpu_rdata_s = mem_rdata;
          state_d     = DONE;
        end else if (!req_s) begin
          state_d = IDLE;
        end else begin
          state_d = DATA;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Outputs are forced quiet while reset is held, including the pass-through path.
  assign cpu_resp        = reset & cpu_resp_s;
  assign cpu_rdata       = reset ? cpu_rdata_s   : 16'h0000;
  assign mem_address     = reset ? mem_address_s : 16'h0000;
  assign mem_read        = reset & mem_read_s;
  assign mem_write       = reset & mem_write_s;
  assign mem_byte_enable = reset ? mem_be_s      : 2'b00;
  assign mem_wdata       = reset ? mem_wdata_s   : 16'h0000;

endmodule

// File: tb/tb_dcache_indirect_ctrl.sv
// Self-checking bench for dcache_indirect_ctrl: vector table, directed multi-cycle sequences,
// and randomized transactions against a transaction-level memory/latency model.
module tb_dcache_indirect_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        indirect = 1'b0;
  logic [15:0] cpu_address = 16'h0000;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [1:0]  cpu_byte_enable = 2'b00;
  logic [15:0] cpu_wdata = 16'h0000;
  logic        cpu_resp;
  logic [15:0] cpu_rdata;
  logic [15:0] mem_address;
  logic        mem_read, mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  // Memory environment: manual mode for table vectors, automatic responder with latency lat otherwise.
  logic [15:0] env_mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic        mem_auto = 1'b0;
  logic        man_resp = 1'b0;
  logic [15:0] man_rdata = 16'h0000;
  int          lat = 1;
  int          wait_cnt = 0;
  logic        auto_resp;

  always #5 clk = ~clk;

  dcache_indirect_ctrl dut (
    .clk(clk), .reset(reset), .indirect(indirect),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_byte_enable(cpu_byte_enable), .cpu_wdata(cpu_wdata),
    .cpu_resp(cpu_resp), .cpu_rdata(cpu_rdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd, input logic [1:0] be);
    return {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
  endfunction

  assign auto_resp = (mem_read || mem_write) && ((wait_cnt + 1) >= lat);
  assign mem_resp  = mem_auto ? auto_resp : man_resp;
  assign mem_rdata = mem_auto ? (auto_resp ? env_mem[mem_address] : 16'hDEAD) : man_rdata;

  always @(posedge clk) begin
    if (!(mem_read || mem_write) || auto_resp) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (mem_auto && auto_resp && mem_write)
      env_mem[mem_address] <= merge(env_mem[mem_address], mem_wdata, mem_byte_enable);
  end

  function automatic logic [63:0] outs();
    return {11'b0, cpu_resp, cpu_rdata, mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ind, input logic rd, input logic wr, input logic [1:0] be,
                       input logic [15:0] addr, input logic [15:0] wd);
    indirect = ind; cpu_read = rd; cpu_write = wr;
    cpu_byte_enable = be; cpu_address = addr; cpu_wdata = wd;
  endtask

  typedef struct {
    logic ind, rd, wr; logic [1:0] be; logic [15:0] addr, wd; logic mresp; logic [15:0] mrd;
    logic e_resp; logic [15:0] e_rdata, e_maddr; logic e_mrd, e_mwr; logic [1:0] e_mbe; logic [15:0] e_mwd;
  } vec_t;
  vec_t vt [6];

  task automatic sti_check(input logic [1:0] be, input logic [15:0] exp_addr, input string name);
    @(posedge clk); #1 drive(1'b1, 1'b0, 1'b1, be, 16'h0100, 16'hAB00);
    repeat (4) @(negedge clk);
    chk(name, {mem_write, mem_read, mem_address, mem_byte_enable, mem_wdata, cpu_resp},
        {1'b1, 1'b0, exp_addr, be, 16'hAB00, 1'b1});
    @(posedge clk); #1 drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ind, is_rd, got, bad_rd;
    logic [1:0]  be;
    logic [15:0] addr, wd, p, target, exp_rdata, act_rdata;
    int          k, cyc, exp_cyc;

    vt[0] = '{1'b0,1'b1,1'b0,2'b11,16'h0040,16'h0000,1'b1,16'hBEEF, 1'b1,16'hBEEF,16'h0040,1'b1,1'b0,2'b11,16'h0000};
    vt[1] = '{1'b0,1'b1,1'b0,2'b01,16'h1235,16'h00FF,1'b0,16'h5555, 1'b0,16'h5555,16'h1235,1'b1,1'b0,2'b01,16'h00FF};
    vt[2] = '{1'b0,1'b0,1'b1,2'b10,16'h2000,16'hAB00,1'b1,16'h0000, 1'b1,16'h0000,16'h2000,1'b0,1'b1,2'b10,16'hAB00};
    vt[3] = '{1'b0,1'b1,1'b1,2'b11,16'h3000,16'h1111,1'b0,16'h0000, 1'b0,16'h0000,16'h3000,1'b1,1'b0,2'b11,16'h1111};
    vt[4] = '{1'b0,1'b0,1'b0,2'b00,16'hFFFF,16'hFFFF,1'b0,16'h0000, 1'b0,16'h0000,16'hFFFF,1'b0,1'b0,2'b00,16'hFFFF};
    vt[5] = '{1'b1,1'b0,1'b0,2'b11,16'h0100,16'h1234,1'b1,16'hCAFE, 1'b0,16'h0000,16'h0000,1'b0,1'b0,2'b00,16'h0000};

    for (int i = 0; i < 65536; i++) begin
      env_mem[i] = 16'(i * 40503 + 12345);
      ref_mem[i] = 16'(i * 40503 + 12345);
    end

    // Reset holds every output quiet even with a pass-through request present.
    drive(1'b0, 1'b1, 1'b0, 2'b11, 16'h0040, 16'h1234);
    man_resp = 1'b1; man_rdata = 16'hBEEF;
    #3 chk("reset_outputs", outs(), 64'h0);
    #9 reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive(vt[i].ind, vt[i].rd, vt[i].wr, vt[i].be, vt[i].addr, vt[i].wd);
      man_resp = vt[i].mresp; man_rdata = vt[i].mrd;
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(),
          {11'b0, vt[i].e_resp, vt[i].e_rdata, vt[i].e_maddr, vt[i].e_mrd, vt[i].e_mwr, vt[i].e_mbe, vt[i].e_mwd});
    end
    @(posedge clk); #1 drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000); man_resp = 1'b0;

    // LDI with single-cycle hits.
    mem_auto = 1'b1; lat = 1;
    env_mem[16'h0100] = 16'h0200; env_mem[16'h0200] = 16'h1234;
    @(posedge clk); #1 drive(1'b1, 1'b1, 1'b0, 2'b11, 16'h0100, 16'h0000);
    @(negedge clk); chk("ldi_c1_idle", {mem_read, mem_write, cpu_resp}, 64'h0);
    @(negedge clk); chk("ldi_c2_ptr", {mem_read, mem_address, mem_byte_enable, cpu_resp}, {1'b1, 16'h0100, 2'b11, 1'b0});
    @(negedge clk); chk("ldi_c3_gap", {mem_read, mem_write, cpu_resp}, 64'h0);
    @(negedge clk); chk("ldi_c4_data", {mem_read, mem_address, cpu_resp, cpu_rdata}, {1'b1, 16'h0200, 1'b1, 16'h1234});
    @(posedge clk); #1 drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    @(negedge clk); chk("ldi_done", {mem_read, mem_write, cpu_resp, cpu_rdata}, 64'h0);

    // STI through pointer 0x0301, byte and word masks.
    env_mem[16'h0100] = 16'h0301;
    sti_check(2'b10, 16'h0301, "sti_byte");
`ifdef DCACHE_INDIRECT_ALIGN_EN
    sti_check(2'b11, 16'h0300, "sti_word");
`else
    sti_check(2'b11, 16'h0301, "sti_word");
`endif

    // Reset during the pointer read, late response while reset is low.
    mem_auto = 1'b0; man_resp = 1'b0;
    @(posedge clk); #1 drive(1'b1, 1'b1, 1'b0, 2'b11, 16'h0100, 16'h0000);
    @(negedge clk);
    @(negedge clk); chk("rst_ptr_before", {mem_read, mem_address}, {1'b1, 16'h0100});
    #2 reset = 1'b0;
    #1 chk("rst_ptr_immediate", outs(), 64'h0);
    @(posedge clk); #1 man_resp = 1'b1; man_rdata = 16'h7777;
    @(negedge clk); chk("rst_late_resp", outs(), 64'h0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk); chk("rst_release_idle", {mem_read, cpu_resp}, 64'h0);
    @(posedge clk); #1 man_resp = 1'b0; drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);

    // Request withdrawn in DATA: controller must be back in IDLE pass-through next cycle.
    mem_auto = 1'b1; lat = 3;
    env_mem[16'h0100] = 16'h0200;
    #1 drive(1'b1, 1'b1, 1'b0, 2'b11, 16'h0100, 16'h0000);
    repeat (6) @(negedge clk);
    chk("wd_data", {mem_read, mem_address, cpu_resp}, {1'b1, 16'h0200, 1'b0});
    @(posedge clk); #1 drive(1'b1, 1'b0, 1'b0, 2'b11, 16'h0100, 16'h0000);
    @(negedge clk); chk("wd_withdrawn", {mem_read, mem_write, cpu_resp}, 64'h0);
    @(posedge clk); #1 drive(1'b0, 1'b1, 1'b0, 2'b11, 16'h0ABC, 16'h0000);
    @(negedge clk); chk("wd_idle_next", {mem_read, mem_address, cpu_resp}, {1'b1, 16'h0ABC, 1'b0});
    @(posedge clk); #1 drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);

    // Randomized plain and indirect transactions against the transaction-level model.
    for (int i = 0; i < 65536; i++) begin
      env_mem[i] = 16'(i * 40503 + 12345);
      ref_mem[i] = 16'(i * 40503 + 12345);
    end
    for (int n = 0; n < 60; n++) begin
      ind  = 1'($urandom_range(0, 1));
      lat  = int'($urandom_range(1, 4));
      k    = int'($urandom_range(0, 3));
      be   = 2'($urandom_range(1, 3));
      addr = 16'($urandom);
      wd   = 16'($urandom);
      is_rd = (k != 1);
      if (ind) begin
        p = ref_mem[addr];
`ifdef DCACHE_INDIRECT_ALIGN_EN
        if (be == 2'b11) p[0] = 1'b0;
`endif
        target  = p;
        exp_cyc = 2 + 2 * lat;
      end else begin
        target  = addr;
        exp_cyc = lat;
      end
      exp_rdata = ref_mem[target];
      if (!is_rd) ref_mem[target] = merge(ref_mem[target], wd, be);

      @(posedge clk); #1 drive(ind, (k != 1), (k == 1) || (k == 2), be, addr, wd);
      cyc = 0; got = 1'b0; bad_rd = 1'b0; act_rdata = 16'h0000;
      while (!got && cyc < 60) begin
        @(negedge clk);
        cyc++;
        if (cpu_resp) begin
          got = 1'b1;
          act_rdata = cpu_rdata;
        end else if (ind && cyc > 1 && cpu_rdata != 16'h0000) begin
          bad_rd = 1'b1;
        end
      end
      chk($sformatf("rnd%0d_resp", n), got, 1'b1);
      chk($sformatf("rnd%0d_latency", n), cyc, exp_cyc);
      if (is_rd) chk($sformatf("rnd%0d_rdata", n), act_rdata, exp_rdata);
      if (ind) chk($sformatf("rnd%0d_rdata_zero", n), bad_rd, 1'b0);
      @(posedge clk); #1 drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
      if (ind) begin
        @(negedge clk);
        chk($sformatf("rnd%0d_done", n), {cpu_resp, mem_read, mem_write}, 64'h0);
      end
      if (!is_rd) chk($sformatf("rnd%0d_mem", n), env_mem[target], ref_mem[target]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
